// File: rtl/opt_resp_checker.sv
// ---------------------------------------------------------------------------
// opt_resp_checker
//
// On-chip response checker for the opt_check family of combinational blocks.
// It watches the stimulus {a,b,c} driven to the block and the block's output
// y over a window of WINDOW accepted samples. It compares y against the golden
// function a & b & c, and reports how many samples mismatched, where the first
// mismatch happened and whether the run passed.
//
// Optional feature: define CHK_MISR_EN to build a MISR signature over the
// accepted {a,b,c,y} samples. Without it, signature is constant 0 and no MISR
// logic exists.
//
// Parameters
//   WINDOW  accepted samples per run (1 .. 2^CNT_W-1)
//   CNT_W   width of sample / error counters
//   SIG_W   MISR width (used only with CHK_MISR_EN)
//   POLY    MISR feedback polynomial (SIG_W LSBs)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset; clears everything
//   start          begins a run (accepted in IDLE and DONE only)
//   sample_en      current a/b/c/y is a valid sample
//   a, b, c        stimulus bits as driven to the block under check
//   y              output of the block under check
//   busy           high while a run is in progress
//   done           high while results are being held
//   pass           done and no mismatches
//   sample_cnt     samples accepted this run
//   err_cnt        mismatches this run (saturating)
//   first_err_vld  first_err_idx / first_err_vec are valid
//   first_err_idx  0-based sample index of the first mismatch
//   first_err_vec  {a,b,c,y} of the first mismatch
//   signature      MISR result (0 without CHK_MISR_EN)
// ---------------------------------------------------------------------------
module opt_resp_checker #(
  parameter int unsigned      WINDOW = 300,
  parameter int unsigned      CNT_W  = 16,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       first_err_vec,
  output logic [SIG_W-1:0] signature
);

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Error counter increments but sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               first_err_vld_q, first_err_vld_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic [3:0]         first_err_vec_q, first_err_vec_d;

  logic               clear;
  logic               accept;
  logic               mismatch;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last;

  // start only counts outside RUN; it wipes the previous result.
  assign clear    = start && (state_q != S_RUN);
  assign accept   = sample_en && (state_q == S_RUN);
  assign mismatch = (y != (a & b & c));
  assign cnt_inc  = sample_cnt_q + CNT_W'(1);
  assign last     = (cnt_inc == WIN_C);

  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vec_d = first_err_vec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_RUN;
          sample_cnt_d    = '0;
          err_cnt_d       = '0;
          first_err_vld_d = 1'b0;
          first_err_idx_d = '0;
          first_err_vec_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          sample_cnt_d = cnt_inc;
          if (mismatch) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (!first_err_vld_q) begin
              first_err_vld_d = 1'b1;
              first_err_idx_d = sample_cnt_q;
              first_err_vec_d = {a, b, c, y};
            end
          end
          // The closing sample is checked above and ends the run on this edge.
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
      first_err_vec_q <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vec_q <= first_err_vec_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign sample_cnt    = sample_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vec = first_err_vec_q;

`ifdef CHK_MISR_EN
  // One MISR step: shift left with polynomial feedback from the MSB, then
  // fold the 4-bit sample into the low bits.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [3:0]       v);
    logic [SIG_W-1:0] fb;
    fb        = s[SIG_W-1] ? POLY : '0;
    misr_step = ({s[SIG_W-2:0], 1'b0} ^ fb) ^ SIG_W'(v);
  endfunction

  logic [SIG_W-1:0] sig_q, sig_d;

  // Signature advances only on accepted samples, so it freezes in DONE.
  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (accept) begin
      sig_d = misr_step(sig_q, {a, b, c, y});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  // No MISR in this build; POLY is folded in only so it is referenced.
  assign signature = POLY & '0;
`endif

endmodule

// File: tb/tb_opt_resp_checker.sv
module tb_opt_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, sample_en, a, b, c, y;

  // WINDOW=4, CNT_W=16
  logic        busy4, done4, pass4, vld4;
  logic [15:0] cnt4, err4, idx4, sig4;
  logic [3:0]  vec4;
  // WINDOW=3, CNT_W=2
  logic        busy3, done3, pass3, vld3;
  logic [1:0]  cnt3, err3, idx3;
  logic [3:0]  vec3;
  logic [15:0] sig3;
  // WINDOW=1
  logic        busy1, done1, pass1, vld1;
  logic [15:0] cnt1, err1, idx1, sig1;
  logic [3:0]  vec1;
  // WINDOW=2
  logic        busy2, done2, pass2, vld2;
  logic [15:0] cnt2, err2, idx2, sig2;
  logic [3:0]  vec2;

  opt_resp_checker #(.WINDOW(4), .CNT_W(16), .SIG_W(16), .POLY(16'h1021)) u4 (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .y(y), .busy(busy4), .done(done4), .pass(pass4),
    .sample_cnt(cnt4), .err_cnt(err4), .first_err_vld(vld4),
    .first_err_idx(idx4), .first_err_vec(vec4), .signature(sig4));

  opt_resp_checker #(.WINDOW(3), .CNT_W(2), .SIG_W(16), .POLY(16'h1021)) u3 (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .y(y), .busy(busy3), .done(done3), .pass(pass3),
    .sample_cnt(cnt3), .err_cnt(err3), .first_err_vld(vld3),
    .first_err_idx(idx3), .first_err_vec(vec3), .signature(sig3));

  opt_resp_checker #(.WINDOW(1), .CNT_W(16), .SIG_W(16), .POLY(16'h1021)) u1 (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .y(y), .busy(busy1), .done(done1), .pass(pass1),
    .sample_cnt(cnt1), .err_cnt(err1), .first_err_vld(vld1),
    .first_err_idx(idx1), .first_err_vec(vec1), .signature(sig1));

  opt_resp_checker #(.WINDOW(2), .CNT_W(16), .SIG_W(16), .POLY(16'h1021)) u2 (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .c(c), .y(y), .busy(busy2), .done(done2), .pass(pass2),
    .sample_cnt(cnt2), .err_cnt(err2), .first_err_vld(vld2),
    .first_err_idx(idx2), .first_err_vec(vec2), .signature(sig2));

  int n_chk  = 0;
  int n_fail = 0;

  // Samples accepted in the current run, in order.
  logic [3:0] smp[$];

  // Expected results from the list of accepted samples.
  int         e_err;
  bit         e_vld;
  int         e_idx;
  logic [3:0] e_vec;
  logic [15:0] e_sig;

  task automatic model(input int n, input int cw);
    int errs;
    int lim;
    logic [3:0] s;
    errs  = 0;
    e_vld = 1'b0;
    e_idx = 0;
    e_vec = 4'h0;
    e_sig = 16'h0;
    for (int i = 0; i < n; i++) begin
      s = smp[i];
      if (s[0] != (s[3] & s[2] & s[1])) begin
        if (!e_vld) begin
          e_vld = 1'b1;
          e_idx = i;
          e_vec = s;
        end
        errs++;
      end
      e_sig = (e_sig * 2) ^ (e_sig[15] ? 16'h1021 : 16'h0) ^ {12'h0, s};
    end
    lim   = (1 << cw) - 1;
    e_err = (errs > lim) ? lim : errs;
`ifndef CHK_MISR_EN
    e_sig = 16'h0;
`endif
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sample_en = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; sample_en = 1'b0;
    cyc();
    start = 1'b0;
    smp.delete();
  endtask

  // Present one sample for one edge; record it if it is expected to be taken.
  task automatic feed(input logic [3:0] v, input bit rec);
    {a, b, c, y} = v;
    sample_en = 1'b1;
    cyc();
    sample_en = 1'b0;
    if (rec) smp.push_back(v);
  endtask

  function automatic logic [3:0] rand_vec(input bit good);
    logic [2:0] abc;
    abc = 3'($urandom_range(0, 7));
    return {abc, good ? (&abc) : ~(&abc)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sample_en = 1'b1; {a, b, c, y} = 4'b1110;
    cyc();
    reset = 1'b0;
    n_chk++;
    if ({busy4, done4, pass4, vld4} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy4, done4, pass4, vld4});
    end
    n_chk++;
    if ({cnt4, err4, idx4, vec4, sig4} !== 68'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {cnt4, err4, idx4, vec4, sig4});
    end
    // sample_en in IDLE is ignored
    cyc();
    sample_en = 1'b0;
    n_chk++;
    if (cnt4 !== 16'd0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got cnt=%0d busy=%b expected cnt=0 busy=0", cnt4, busy4);
    end
  endtask

  task automatic test_clean_run();
    do_reset();
    do_start();
    n_chk++;
    if (busy4 !== 1'b1 || cnt4 !== 16'd0) begin
      n_fail++; $display("FAIL clean_start: got busy=%b cnt=%0d expected busy=1 cnt=0", busy4, cnt4);
    end
    for (int i = 0; i < 4; i++) begin
      feed(rand_vec(1'b1), 1'b1);
      if (i < 3) begin
        n_chk++;
        if (busy4 !== 1'b1 || done4 !== 1'b0 || cnt4 !== 16'(i + 1)) begin
          n_fail++; $display("FAIL clean_progress: got busy=%b done=%b cnt=%0d expected 1 0 %0d", busy4, done4, cnt4, i + 1);
        end
      end
    end
    n_chk++;
    if ({busy4, done4, pass4, vld4} !== 4'b0110 || cnt4 !== 16'd4 || err4 !== 16'd0) begin
      n_fail++; $display("FAIL clean_done: got flags=%b cnt=%0d err=%0d expected 0110 4 0", {busy4, done4, pass4, vld4}, cnt4, err4);
    end
  endtask

  task automatic test_errors();
    logic [3:0] vecs [4];
    vecs[0] = 4'b1110; vecs[1] = 4'b0000; vecs[2] = 4'b1111; vecs[3] = 4'b0001;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) feed(vecs[i], 1'b1);
    model(4, 16);
    n_chk++;
    if ({err4, vld4, idx4, vec4} !== {16'(e_err), e_vld, 16'(e_idx), e_vec}) begin
      n_fail++; $display("FAIL errors_result: got err=%0d vld=%b idx=%0d vec=%b expected %0d %b %0d %b", err4, vld4, idx4, vec4, e_err, e_vld, e_idx, e_vec);
    end
    n_chk++;
    if (done4 !== 1'b1 || pass4 !== 1'b0) begin
      n_fail++; $display("FAIL errors_pass: got done=%b pass=%b expected 1 0", done4, pass4);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      feed(rand_vec(($urandom_range(0, 3) != 0)), 1'b1);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          {a, b, c, y} = 4'($urandom_range(0, 15));
          cyc();
          n_chk++;
          if (busy4 !== 1'b1 || cnt4 !== 16'(i + 1)) begin
            n_fail++; $display("FAIL gap_hold: got busy=%b cnt=%0d expected 1 %0d", busy4, cnt4, i + 1);
          end
        end
      end
    end
    model(4, 16);
    n_chk++;
    if ({done4, pass4, cnt4, err4, vld4, idx4, vec4} !== {1'b1, (e_err == 0), 16'd4, 16'(e_err), e_vld, 16'(e_idx), e_vec}) begin
      n_fail++; $display("FAIL gap_result: got done=%b pass=%b cnt=%0d err=%0d vld=%b idx=%0d vec=%b expected err=%0d vld=%b idx=%0d vec=%b", done4, pass4, cnt4, err4, vld4, idx4, vec4, e_err, e_vld, e_idx, e_vec);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    feed(4'b1110, 1'b1);
    feed(4'b0001, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_chk++;
    if ({busy4, done4, pass4, vld4, cnt4, err4, idx4, vec4, sig4} !== 72'h0) begin
      n_fail++; $display("FAIL midreset_clear: got %h expected 0", {busy4, done4, pass4, vld4, cnt4, err4, idx4, vec4, sig4});
    end
    do_start();
    for (int i = 0; i < 4; i++) feed(rand_vec(1'b1), 1'b1);
    n_chk++;
    if (cnt4 !== 16'd4 || done4 !== 1'b1 || pass4 !== 1'b1 || err4 !== 16'd0 || vld4 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_rerun: got cnt=%0d done=%b pass=%b err=%0d vld=%b expected 4 1 1 0 0", cnt4, done4, pass4, err4, vld4);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_start();
    feed(rand_vec(1'b0), 1'b1);
    start = 1'b1;
    feed(rand_vec(1'b0), 1'b1);
    start = 1'b0;
    n_chk++;
    if (busy3 !== 1'b1 || cnt3 !== 2'd2) begin
      n_fail++; $display("FAIL sat_start_in_run: got busy=%b cnt=%0d expected 1 2", busy3, cnt3);
    end
    feed(rand_vec(1'b0), 1'b1);
    model(3, 2);
    n_chk++;
    if ({done3, pass3, err3, vld3, idx3, vec3} !== {1'b1, 1'b0, 2'(e_err), e_vld, 2'(e_idx), e_vec}) begin
      n_fail++; $display("FAIL sat_result: got done=%b pass=%b err=%0d vld=%b idx=%0d vec=%b expected 1 0 %0d %b %0d %b", done3, pass3, err3, vld3, idx3, vec3, e_err, e_vld, e_idx, e_vec);
    end
    // start together with sample_en in DONE: restart, sample not taken
    start = 1'b1;
    feed(rand_vec(1'b0), 1'b0);
    start = 1'b0;
    n_chk++;
    if ({busy3, done3, pass3, vld3, cnt3, err3} !== {4'b1000, 2'd0, 2'd0}) begin
      n_fail++; $display("FAIL sat_restart: got flags=%b cnt=%0d err=%0d expected 1000 0 0", {busy3, done3, pass3, vld3}, cnt3, err3);
    end
  endtask

  task automatic test_window1();
    logic [3:0] v;
    do_reset();
    do_start();
    v = rand_vec($urandom_range(0, 1) == 1);
    feed(v, 1'b1);
    model(1, 16);
    n_chk++;
    if ({busy1, done1, pass1, cnt1, err1, vld1, vec1} !== {1'b0, 1'b1, (e_err == 0), 16'd1, 16'(e_err), e_vld, e_vec}) begin
      n_fail++; $display("FAIL window1: got busy=%b done=%b pass=%b cnt=%0d err=%0d vld=%b vec=%b expected err=%0d vld=%b vec=%b", busy1, done1, pass1, cnt1, err1, vld1, vec1, e_err, e_vld, e_vec);
    end
  endtask

  task automatic test_misr();
    logic [15:0] held;
    do_reset();
    do_start();
    feed(4'b0001, 1'b1);
    feed(4'b1111, 1'b1);
    model(2, 16);
    n_chk++;
    if (done2 !== 1'b1 || sig2 !== e_sig) begin
      n_fail++; $display("FAIL misr_sig: got done=%b sig=%h expected 1 %h", done2, sig2, e_sig);
    end
    held = e_sig;
    feed(4'b1010, 1'b0);
    n_chk++;
    if (sig2 !== held || cnt2 !== 16'd2 || done2 !== 1'b1) begin
      n_fail++; $display("FAIL misr_frozen: got sig=%h cnt=%0d done=%b expected %h 2 1", sig2, cnt2, done2, held);
    end
    do_start();
    n_chk++;
    if (sig2 !== 16'h0 || cnt2 !== 16'd0) begin
      n_fail++; $display("FAIL misr_clear: got sig=%h cnt=%0d expected 0 0", sig2, cnt2);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          {a, b, c, y} = 4'($urandom_range(0, 15));
          cyc();
        end
        feed(rand_vec($urandom_range(0, 2) != 0), 1'b1);
      end
      model(4, 16);
      n_chk++;
      if ({done4, pass4, cnt4, err4, vld4, idx4, vec4} !== {1'b1, (e_err == 0), 16'd4, 16'(e_err), e_vld, 16'(e_idx), e_vec}) begin
        n_fail++; $display("FAIL random_run%0d: got pass=%b err=%0d vld=%b idx=%0d vec=%b expected %b %0d %b %0d %b", r, pass4, err4, vld4, idx4, vec4, (e_err == 0), e_err, e_vld, e_idx, e_vec);
      end
      model(2, 16);
      n_chk++;
      if (sig2 !== e_sig) begin
        n_fail++; $display("FAIL random_sig%0d: got %h expected %h", r, sig2, e_sig);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sample_en = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; y = 1'b0;
    cyc();
    test_reset();
    test_clean_run();
    test_errors();
    test_gaps();
    test_reset_mid();
    test_saturate();
    test_window1();
    test_misr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
